btn_cmd_ctrl: RTL and testbench

Debounces the three synchronized push-button levels and turns them into the CPU run-control commands: one-cycle `dbg_run_core` / `dbg_halt_core` pulses and a 4-phase `step_cycle` / `step_ack` request. Sits between the input resynchronizer and the CPU core, and replaces the bare one-register edge detectors in the top level. A press held or bouncing for any length of time yields exactly one command.

---
 rtl/btn_cmd_pkg.sv | 14 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/btn_cmd_ctrl.sv | 84 ++++++++
 tb/tb_btn_cmd_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cmd_pkg.sv
// Shared constants for the push-button run-control block: step handshake state
// encoding and the default debounce interval.
package btn_cmd_pkg;

  typedef logic [1:0] step_state_t;

  localparam step_state_t IDLE = 2'd0;
  localparam step_state_t REQ  = 2'd1;
  localparam step_state_t DROP = 2'd2;

  // 10 ms at the 60 MHz CPU clock
  localparam int unsigned DEBOUNCE_10MS_60MHZ = 600000;

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: accepts a level change only after it has been stable for
// DEBOUNCE_CYCLES consecutive cycles, and flags the cycle the accepted level rises.
module btn_debounce import btn_cmd_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_60MHZ,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_a,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             stab_q;
  logic             prev_q;

  // Any sample equal to the stable level restarts the count, so glitches never accumulate.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      cnt_q  <= '0;
      stab_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      prev_q <= stab_q;
      if (raw == stab_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        stab_q <= raw;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = stab_q;
  assign rise  = stab_q & ~prev_q;

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Turns the three debounced buttons into run/halt command pulses and a 4-phase
// single-step request towards the CPU core.
module btn_cmd_ctrl import btn_cmd_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_60MHZ,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:1] buttons,
  input  logic       cpu_running,
  input  logic       step_ack,
  output logic [3:1] btn_level,
  output logic       dbg_run_core,
  output logic       dbg_halt_core,
  output logic       step_cycle,
  output logic       step_busy
);

  logic [3:1]  rise;
  logic        run_q;
  logic        halt_q;
  logic        pending_q;
  logic        pending_d;
  logic        pending_keep;
  logic        step_press;
  step_state_t state_q;
  step_state_t state_d;

  for (genvar i = 1; i <= 3; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .rst_a(rst_a),
      .raw  (buttons[i]),
      .level(btn_level[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    step_press   = rise[3] & ~cpu_running;
    // A press during a handshake is remembered once; a run command cancels it.
    pending_keep = (pending_q | (step_press & (state_q != IDLE))) & ~run_q;
    state_d      = state_q;
    pending_d    = pending_keep;
    case (state_q)
      IDLE: begin
        if (step_press) state_d = REQ;
      end
      REQ: begin
        if (step_ack) state_d = DROP;
      end
      DROP: begin
        if (!step_ack) begin
          state_d   = pending_keep ? REQ : IDLE;
          pending_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      run_q     <= 1'b0;
      halt_q    <= 1'b0;
      pending_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      halt_q    <= rise[2];
      run_q     <= rise[1] & ~rise[2];
      pending_q <= pending_d;
      state_q   <= state_d;
    end
  end

  assign dbg_run_core  = run_q;
  assign dbg_halt_core = halt_q;
  assign step_cycle    = (state_q == REQ);
  assign step_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Bench for btn_cmd_ctrl: reference model feeds a scoreboard that a negedge monitor
// drains; directed scenarios plus randomized button/run/ack activity.
module tb_btn_cmd_ctrl;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic [3:1] buttons = 3'b000;
  logic       cpu_running = 1'b0;
  logic       step_ack = 1'b0;
  logic [3:1] btn_level;
  logic       dbg_run_core;
  logic       dbg_halt_core;
  logic       step_cycle;
  logic       step_busy;

  btn_cmd_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .clk          (clk),
    .rst_a        (rst_a),
    .buttons      (buttons),
    .cpu_running  (cpu_running),
    .step_ack     (step_ack),
    .btn_level    (btn_level),
    .dbg_run_core (dbg_run_core),
    .dbg_halt_core(dbg_halt_core),
    .step_cycle   (step_cycle),
    .step_busy    (step_busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [3:1] lvl;
    logic       busy;
    logic       sc;
  } lvl_t;

  typedef struct {
    int cyc;
    int kind;  // 0 run pulse, 1 halt pulse
  } ev_t;

  lvl_t lvl_q[$];
  ev_t  ev_q[$];

  // Reference model: accepted levels, run-length of disagreeing samples, handshake phase.
  int         run_len[1:3];
  logic [3:1] m_lvl = '0;
  logic [3:1] went_up = '0;
  logic [3:1] r;
  int         m_phase = 0;  // 0 idle, 1 requesting, 2 waiting for ack to drop
  bit         m_pend = 0;
  bit         m_run = 0;
  bit         m_halt = 0;
  bit         press;
  bit         keep;
  lvl_t       le_push;
  ev_t        ev_push;

  initial begin
    for (int i = 1; i <= 3; i++) run_len[i] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_a) begin
        for (int i = 1; i <= 3; i++) run_len[i] = 0;
        m_lvl = '0; went_up = '0; m_phase = 0; m_pend = 0; m_run = 0; m_halt = 0;
      end else begin
        r     = went_up;
        press = r[3] && !cpu_running;
        keep  = (m_pend || (press && m_phase != 0)) && !m_run;
        m_pend = keep;
        if (m_phase == 0) begin
          if (press) m_phase = 1;
        end else if (m_phase == 1) begin
          if (step_ack) m_phase = 2;
        end else if (!step_ack) begin
          m_phase = keep ? 1 : 0;
          m_pend  = 0;
        end
        m_halt = r[2];
        m_run  = r[1] && !r[2];
        for (int i = 1; i <= 3; i++) begin
          went_up[i] = 1'b0;
          if (buttons[i] != m_lvl[i]) run_len[i]++;
          else run_len[i] = 0;
          if (run_len[i] == int'(DEB)) begin
            m_lvl[i]   = buttons[i];
            run_len[i] = 0;
            went_up[i] = buttons[i];
          end
        end
      end
      le_push.cyc  = cyc;
      le_push.lvl  = m_lvl;
      le_push.busy = (m_phase != 0);
      le_push.sc   = (m_phase == 1);
      lvl_q.push_back(le_push);
      if (m_halt) begin ev_push.cyc = cyc; ev_push.kind = 1; ev_q.push_back(ev_push); end
      if (m_run)  begin ev_push.cyc = cyc; ev_push.kind = 0; ev_q.push_back(ev_push); end
    end
  end

  // Monitor: compares DUT against the scoreboard and keeps scenario statistics.
  int   halt_cnt = 0, run_cnt = 0, rise_cnt = 0, busy_cnt = 0;
  int   last_halt_cyc = 0, hi_len = 0, last_hi_len = 0, last_rise_gap = 0;
  int   ack_low_cyc = 0;
  logic prev_sc = 1'b0;
  lvl_t le;
  ev_t  ev;
  bit   exp_run, exp_halt;

  initial forever begin
    @(negedge clk);
    if (lvl_q.size() > 0) begin
      le = lvl_q.pop_front();
      chk("btn_level", 32'(btn_level), 32'(le.lvl));
      chk("step_busy", 32'(step_busy), 32'(le.busy));
      chk("step_cycle", 32'(step_cycle), 32'(le.sc));
      exp_run  = 0;
      exp_halt = 0;
      while (ev_q.size() > 0 && ev_q[0].cyc <= le.cyc) begin
        ev = ev_q.pop_front();
        if (ev.cyc < le.cyc) begin
          checks++;
          errors++;
          $display("FAIL stale_event kind %0d: got none expected pulse at cycle %0d", ev.kind,
                   ev.cyc);
        end else if (ev.kind == 1) exp_halt = 1;
        else exp_run = 1;
      end
      if (dbg_halt_core || exp_halt) chk("halt_pulse", 32'(dbg_halt_core), 32'(exp_halt));
      if (dbg_run_core || exp_run) chk("run_pulse", 32'(dbg_run_core), 32'(exp_run));
    end
    if (dbg_halt_core) begin halt_cnt++; last_halt_cyc = cyc; end
    if (dbg_run_core) run_cnt++;
    if (step_busy) busy_cnt++;
    if (step_cycle && !prev_sc) begin rise_cnt++; last_rise_gap = cyc - ack_low_cyc; end
    if (step_cycle) hi_len++;
    else if (prev_sc) begin last_hi_len = hi_len; hi_len = 0; end
    prev_sc = step_cycle;
  end

  // CPU acknowledge responder: raise after ack_hi_n cycles of request, drop after ack_lo_n.
  int ack_hi_n = 4, ack_lo_n = 3, a_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_a) begin
      step_ack = 1'b0;
      a_cnt = 0;
    end else if (!step_ack) begin
      if (step_cycle) begin
        a_cnt++;
        if (a_cnt >= ack_hi_n) begin step_ack = 1'b1; a_cnt = 0; end
      end else a_cnt = 0;
    end else begin
      if (!step_cycle) begin
        a_cnt++;
        if (a_cnt >= ack_lo_n) begin step_ack = 1'b0; a_cnt = 0; ack_low_cyc = cyc; end
      end else a_cnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int h0, r0, s0, b0, t0;
  int pat[5] = '{1, 0, 1, 0, 1};

  initial begin
    // Reset state
    tick(3);
    chk("rst_btn_level", 32'(btn_level), 0);
    chk("rst_run", 32'(dbg_run_core), 0);
    chk("rst_halt", 32'(dbg_halt_core), 0);
    chk("rst_step_cycle", 32'(step_cycle), 0);
    chk("rst_step_busy", 32'(step_busy), 0);
    rst_a = 1'b1;
    tick(3);

    // Bounce on halt: 1,0,1,0 then hold 1
    h0 = halt_cnt; r0 = run_cnt;
    for (int k = 0; k < 4; k++) begin buttons[2] = pat[k][0]; tick(1); end
    buttons[2] = 1'b1;
    t0 = cyc;
    tick(8);
    chk("bounce_halt_count", 32'(halt_cnt - h0), 1);
    chk("bounce_halt_latency", 32'(last_halt_cyc - t0), 5);
    chk("bounce_level", 32'(btn_level[2]), 1);
    buttons[2] = 1'b0;
    tick(8);
    chk("release_no_cmd", 32'(halt_cnt - h0 + run_cnt - r0), 1);

    // Simultaneous run and halt
    h0 = halt_cnt; r0 = run_cnt;
    buttons[2:1] = 2'b11;
    tick(6);
    buttons[2:1] = 2'b00;
    tick(8);
    chk("simul_halt_count", 32'(halt_cnt - h0), 1);
    chk("simul_run_count", 32'(run_cnt - r0), 0);

    // Step handshake while halted
    cpu_running = 1'b0;
    s0 = rise_cnt;
    buttons[3] = 1'b1;
    tick(6);
    buttons[3] = 1'b0;
    tick(20);
    chk("step_req_count", 32'(rise_cnt - s0), 1);
    chk("step_high_len", 32'(last_hi_len), 4);
    chk("step_busy_done", 32'(step_busy), 0);

    // Step while running is ignored
    cpu_running = 1'b1;
    s0 = rise_cnt; b0 = busy_cnt;
    buttons[3] = 1'b1;
    tick(6);
    buttons[3] = 1'b0;
    tick(12);
    chk("running_step_req", 32'(rise_cnt - s0), 0);
    chk("running_step_busy", 32'(busy_cnt - b0), 0);
    cpu_running = 1'b0;

    // Pending step: second press queued, third press lost
    ack_hi_n = 30;
    s0 = rise_cnt;
    for (int k = 0; k < 3; k++) begin
      buttons[3] = 1'b1;
      tick(5);
      buttons[3] = 1'b0;
      tick(5);
    end
    tick(55);
    chk("pending_req_count", 32'(rise_cnt - s0), 2);
    chk("pending_rerise_gap", 32'(last_rise_gap), 1);
    chk("pending_busy_done", 32'(step_busy), 0);
    ack_hi_n = 4;

    // Reset during a step request
    buttons[3] = 1'b1;
    tick(5);
    buttons[3] = 1'b0;
    for (int k = 0; k < 20 && !step_cycle; k++) tick(1);
    chk("reach_step_req", 32'(step_cycle), 1);
    rst_a = 1'b0;
    #1;
    chk("midrst_step_cycle", 32'(step_cycle), 0);
    chk("midrst_step_busy", 32'(step_busy), 0);
    chk("midrst_btn_level", 32'(btn_level), 0);
    chk("midrst_pulses", 32'({dbg_run_core, dbg_halt_core}), 0);
    tick(2);
    rst_a = 1'b1;
    h0 = halt_cnt; r0 = run_cnt; s0 = rise_cnt; b0 = busy_cnt;
    tick(15);
    chk("postrst_pulses", 32'(halt_cnt - h0 + run_cnt - r0), 0);
    chk("postrst_step", 32'(rise_cnt - s0 + busy_cnt - b0), 0);

    // Randomized activity against the model
    for (int k = 0; k < 300; k++) begin
      buttons     = 3'($urandom_range(0, 7));
      cpu_running = ($urandom_range(0, 3) == 0);
      ack_hi_n    = $urandom_range(1, 6);
      ack_lo_n    = $urandom_range(1, 4);
      tick($urandom_range(1, 8));
    end
    buttons = 3'b000;
    cpu_running = 1'b0;
    ack_hi_n = 4;
    ack_lo_n = 3;
    tick(80);
    chk("events_drained", 32'(ev_q.size()), 0);
    chk("final_busy", 32'(step_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
